// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Types and constants shared by the SPI RAM slave and its testbench.
//   spi_state_t : FSM state encoding of the SPI slave
//   CMD_*       : 2-bit command codes sent MSB first after SS_n falls
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      WR_ADDR = 3'd2,
      WR_DATA = 3'd3,
      RD_ADDR = 3'd4,
      RD_WAIT = 3'd5,
      RD_DATA = 3'd6,
      DRAIN   = 3'd7
   } spi_state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_core.sv
// -----------------------------------------------------------------------------
// spi_ram_core
// Single-port synchronous memory, MEM_DEPTH x DATA_SIZE, one-cycle registered
// read. A write and a read cannot share a cycle; dout during a write cycle is
// the old content of the written word.
//   clk  : clock, rising edge
//   we   : write enable for this cycle
//   addr : word address (write or read)
//   din  : write data
//   dout : registered read data of mem[addr] from the previous edge
// -----------------------------------------------------------------------------
module spi_ram_core #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [DATA_SIZE-1:0] din,
   output logic [DATA_SIZE-1:0] dout
);

   logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
   logic [DATA_SIZE-1:0] dout_q;

   // NOTE: the storage array has no reset branch; resetting a memory would
   // turn it into a flop bank and block mapping onto RAM macros.
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= din;
      dout_q <= mem_q[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/spi_ram_slave_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_slave_burst
// SPI slave with an embedded RAM. Each SS_n frame carries a 2-bit command
// (write address, write data, read address, read data) followed by its
// payload. The serial bit clock is clk.
//   clk  : system and serial bit clock, rising edge
//   rst  : asynchronous active-high reset (memory contents are kept)
//   SS_n : slave select, active low
//   MOSI : serial input, MSB first
//   MISO : serial output, MSB first, 0 when not shifting read data
//   busy : high whenever the FSM is not IDLE
// Build option: define SPI_BURST_EN to stream consecutive words within one
// frame with auto-incrementing (wrapping) addresses.
// -----------------------------------------------------------------------------
module spi_ram_slave_burst #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy
);
   import spi_pkg::*;

   localparam logic [5:0] ADDR_LAST = 6'(ADDR_SIZE - 1);
   localparam logic [5:0] DATA_LAST = 6'(DATA_SIZE - 1);

   spi_state_t           state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic                 cmd_q, cmd_d;
   logic [ADDR_SIZE-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_SIZE-1:0] data_sh_q, data_sh_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 miso_q, miso_d;
   logic                 busy_q, busy_d;

   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [DATA_SIZE-1:0] mem_din;
   logic [DATA_SIZE-1:0] mem_dout;

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      addr_sh_d = addr_sh_q;
      data_sh_d = data_sh_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      miso_d    = 1'b0;
      mem_we    = 1'b0;
      mem_din   = {data_sh_q[DATA_SIZE-2:0], MOSI};

      if (SS_n) begin
         // Frame end or abort: partial words are dropped, nothing commits.
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = CMD;
               cnt_d   = '0;
            end
            CMD: begin
               cmd_d = MOSI;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd1) begin
                  cnt_d = '0;
                  case ({cmd_q, MOSI})
                     CMD_WR_ADDR: state_d = WR_ADDR;
                     CMD_WR_DATA: state_d = WR_DATA;
                     CMD_RD_ADDR: state_d = RD_ADDR;
                     default:     state_d = RD_WAIT;
                  endcase
               end
            end
            WR_ADDR, RD_ADDR: begin
               addr_sh_d = {addr_sh_q[ADDR_SIZE-2:0], MOSI};
               cnt_d     = cnt_q + 6'd1;
               if (cnt_q == ADDR_LAST) begin
                  if (state_q == WR_ADDR) wr_addr_d = addr_sh_d;
                  else                    rd_addr_d = addr_sh_d;
                  state_d = DRAIN;
               end
            end
            WR_DATA: begin
               data_sh_d = mem_din;
               cnt_d     = cnt_q + 6'd1;
               if (cnt_q == DATA_LAST) begin
                  mem_we = 1'b1;
                  cnt_d  = '0;
`ifdef SPI_BURST_EN
                  wr_addr_d = wr_addr_q + 1'b1;
`else
                  state_d = DRAIN;
`endif
               end
            end
            RD_WAIT: begin
               // mem_dout already holds mem[rd_addr] because reads are
               // issued from rd_addr_d one cycle ahead.
               miso_d    = mem_dout[DATA_SIZE-1];
               data_sh_d = {mem_dout[DATA_SIZE-2:0], 1'b0};
               cnt_d     = '0;
               state_d   = RD_DATA;
            end
            RD_DATA: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == DATA_LAST) begin
                  // All bits sent; this cycle is the MISO=0 gap.
`ifdef SPI_BURST_EN
                  rd_addr_d = rd_addr_q + 1'b1;
                  state_d   = RD_WAIT;
`else
                  state_d = DRAIN;
`endif
               end else begin
                  miso_d    = data_sh_q[DATA_SIZE-1];
                  data_sh_d = {data_sh_q[DATA_SIZE-2:0], 1'b0};
               end
            end
            DRAIN:   state_d = DRAIN;
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // Reads use the next read pointer so a burst increment is visible in
   // mem_dout by the following RD_WAIT cycle.
   assign mem_addr = mem_we ? wr_addr_q : rd_addr_d;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cmd_q     <= 1'b0;
         addr_sh_q <= '0;
         data_sh_q <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         miso_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         addr_sh_q <= addr_sh_d;
         data_sh_q <= data_sh_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         miso_q    <= miso_d;
         busy_q    <= busy_d;
      end
   end

   assign MISO = miso_q;
   assign busy = busy_q;

   spi_ram_core #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE),
      .DATA_SIZE (DATA_SIZE)
   ) u_core (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .din  (mem_din),
      .dout (mem_dout)
   );

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_slave_burst
// Directed bench for spi_ram_slave_burst. Instance u_a uses the default
// 256 x 8 configuration; u_b uses 16 x 16. Both share clk, rst, SS_n and
// MOSI; u_b is only checked in the final step. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spi_ram_slave_burst;

   logic clk = 1'b0;
   logic rst, ss_n, mosi;
   logic miso_a, busy_a, miso_b, busy_b;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   spi_ram_slave_burst u_a (
      .clk (clk), .rst (rst), .SS_n (ss_n), .MOSI (mosi),
      .MISO (miso_a), .busy (busy_a)
   );

   spi_ram_slave_burst #(.MEM_DEPTH(16), .ADDR_SIZE(4), .DATA_SIZE(16)) u_b (
      .clk (clk), .rst (rst), .SS_n (ss_n), .MOSI (mosi),
      .MISO (miso_b), .busy (busy_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic frame_begin(input logic [1:0] cmd);
      @(negedge clk); ss_n = 1'b0; mosi = 1'b0;  // E0 follows
      @(negedge clk); mosi = cmd[1];             // sampled at E1
      @(negedge clk); mosi = cmd[0];             // sampled at E2
   endtask

   task automatic shift_in(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk); mosi = v[i];
      end
   endtask

   task automatic frame_end;
      @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic set_wr_addr(input logic [31:0] a, input int n);
      frame_begin(2'b00); shift_in(a, n); frame_end();
   endtask

   task automatic write_word(input logic [31:0] d, input int n);
      frame_begin(2'b01); shift_in(d, n); frame_end();
   endtask

   // Sets rd_addr, then runs a one-word read frame and collects MISO.
   task automatic read_word(input logic [31:0] a, input int an, input int dn,
                            input bit use_b, input string tag, output logic [31:0] v);
      v = '0;
      frame_begin(2'b10); shift_in(a, an); frame_end();
      frame_begin(2'b11);
      @(negedge clk);                      // RD_WAIT cycle, E3 follows
      for (int i = dn - 1; i >= 0; i--) begin
         @(negedge clk); v[i] = use_b ? miso_b : miso_a;
      end
      @(negedge clk);
      check({tag, "_tail0"}, {31'd0, use_b ? miso_b : miso_a}, 32'd0);
      frame_end();
   endtask

   logic [31:0] rv;
   logic [7:0]  exp_byte;

   initial begin
      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_miso", {31'd0, miso_a}, 32'd0);
      check("reset_busy", {31'd0, busy_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-frame: mem[0]=0x5A, then 0xFF write cut by rst at bit 4.
      set_wr_addr(32'h00, 8);
      write_word(32'h5A, 8);
      set_wr_addr(32'h00, 8);
      frame_begin(2'b01);
      shift_in(32'hF, 4);
      @(posedge clk); #1;
      check("midframe_busy", {31'd0, busy_a}, 32'd1);
      rst = 1'b1; #1;
      check("rst_busy_now", {31'd0, busy_a}, 32'd0);
      check("rst_miso_now", {31'd0, miso_a}, 32'd0);
      @(negedge clk); rst = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      @(negedge clk);
      read_word(32'h00, 8, 8, 1'b0, "rst_read", rv);
      check("rst_no_write", rv, 32'h5A);

      // Single write / read with bitwise MISO check.
      set_wr_addr(32'hA5, 8);
      write_word(32'h3C, 8);
      read_word(32'hA5, 8, 8, 1'b0, "rd_a5", rv);
      exp_byte = 8'h3C;
      for (int i = 7; i >= 0; i--)
         check($sformatf("rd_a5_bit%0d", i), {31'd0, rv[i]}, {31'd0, exp_byte[i]});
      check("idle_busy", {31'd0, busy_a}, 32'd0);

      // Abort: 0x12 at 0x69, then a 5-bit 0xFF write cut by SS_n.
      set_wr_addr(32'h69, 8);
      write_word(32'h12, 8);
      frame_begin(2'b01);
      shift_in(32'h1F, 5);
      frame_end();
      read_word(32'h69, 8, 8, 1'b0, "abort", rv);
      check("abort_keep", rv, 32'h12);
      write_word(32'h77, 8);
`ifdef SPI_BURST_EN
      read_word(32'h6A, 8, 8, 1'b0, "abort_ptr", rv);
`else
      read_word(32'h69, 8, 8, 1'b0, "abort_ptr", rv);
`endif
      check("abort_ptr_kept", rv, 32'h77);

      // Three-word frame at 0xFE with known neighbours.
      set_wr_addr(32'hFF, 8); write_word(32'hAA, 8);
      set_wr_addr(32'h00, 8); write_word(32'hBB, 8);
      set_wr_addr(32'hFE, 8);
      frame_begin(2'b01); shift_in(32'h112233, 24); frame_end();
      read_word(32'hFE, 8, 8, 1'b0, "b_fe", rv);
      check("b_mem_fe", rv, 32'h11);
`ifdef SPI_BURST_EN
      read_word(32'hFF, 8, 8, 1'b0, "b_ff", rv);
      check("b_mem_ff", rv, 32'h22);
      read_word(32'h00, 8, 8, 1'b0, "b_00", rv);
      check("b_mem_00", rv, 32'h33);
      // Burst read of the same three words with a MISO=0 gap between them.
      frame_begin(2'b10); shift_in(32'hFE, 8); frame_end();
      frame_begin(2'b11);
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         rv = '0;
         for (int i = 7; i >= 0; i--) begin
            @(negedge clk); rv[i] = miso_a;
         end
         check($sformatf("burst_rd_w%0d", w), rv, (w == 0) ? 32'h11 : (w == 1) ? 32'h22 : 32'h33);
         @(negedge clk);
         check($sformatf("burst_gap_w%0d", w), {31'd0, miso_a}, 32'd0);
      end
      frame_end();
`else
      read_word(32'hFF, 8, 8, 1'b0, "nb_ff", rv);
      check("nb_mem_ff", rv, 32'hAA);
      read_word(32'h00, 8, 8, 1'b0, "nb_00", rv);
      check("nb_mem_00", rv, 32'hBB);
      write_word(32'h44, 8);
      read_word(32'hFE, 8, 8, 1'b0, "nb_ptr", rv);
      check("nb_wr_addr_fe", rv, 32'h44);
`endif

      // 16 x 16 instance: 0xBEEF at address 0xF.
      set_wr_addr(32'hF, 4);
      write_word(32'hBEEF, 16);
      read_word(32'hF, 4, 16, 1'b1, "p16", rv);
      check("p16_beef", rv, 32'hBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
